decode_stage: RTL and testbench

//  Registered, handshaked instruction decode stage between fetch and execute.

---
 rtl/decode_stage_if.sv | 45 ++++
 rtl/decode_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles the fetch-side handshake, the execute-side handshake, the flush
//   request and the decoded fields for decode_stage.
//   master : environment side. It drives flush_in, instr_valid_in, instr_in,
//            pc_in and dec_ready_in, and it observes everything else.
//   slave  : decode_stage side, which is the mirror of master.
//   Ports:
//     flush_in                    discard every buffered instruction
//     instr_valid_in/ready_out    fetch handshake (instr_in, pc_in)
//     dec_valid_out/ready_in      execute handshake
//     op_code_out .. illegal_out  decoded fields of the head entry
interface decode_stage_if #(
    parameter int ARCH               = 32,
    parameter int REGFILE_ADDR_WIDTH = 5
);
    logic                          flush_in;
    logic                          instr_valid_in;
    logic                          instr_ready_out;
    logic [31:0]                   instr_in;
    logic [ARCH-1:0]               pc_in;
    logic                          dec_valid_out;
    logic                          dec_ready_in;
    logic [6:0]                    op_code_out;
    logic [2:0]                    func3_out;
    logic [6:0]                    func7_out;
    logic [REGFILE_ADDR_WIDTH-1:0] rs1_out;
    logic [REGFILE_ADDR_WIDTH-1:0] rs2_out;
    logic [REGFILE_ADDR_WIDTH-1:0] rd_out;
    logic [ARCH-1:0]               imm_out;
    logic [ARCH-1:0]               pc_out;
    logic [2:0]                    instr_type_out;
    logic                          illegal_out;

    modport master (
        output flush_in, instr_valid_in, instr_in, pc_in, dec_ready_in,
        input  instr_ready_out, dec_valid_out, op_code_out, func3_out, func7_out,
               rs1_out, rs2_out, rd_out, imm_out, pc_out, instr_type_out, illegal_out
    );

    modport slave (
        input  flush_in, instr_valid_in, instr_in, pc_in, dec_ready_in,
        output instr_ready_out, dec_valid_out, op_code_out, func3_out, func7_out,
               rs1_out, rs2_out, rd_out, imm_out, pc_out, instr_type_out, illegal_out
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   Registered, handshaked instruction decode stage between fetch and execute.
//   It splits a 32-bit instruction into opcode, func and register fields and a
//   sign-extended immediate, carries the PC alongside, and flags illegal
//   encodings. An accepted instruction appears on the outputs one cycle later.
//   Ports:
//     clk_in  rising-edge clock
//     rst_in  synchronous, active-high reset
//     bus     decode_stage_if.slave, which carries both handshakes, the flush
//             request and the decoded outputs
//   Parameters:
//     ARCH               datapath and immediate width (32 or 64)
//     REGFILE_ADDR_WIDTH register index width
//     SKID_EN            1: two-entry buffer with a registered ready
//                        0: single register with a combinational ready
module decode_stage #(
    parameter int ARCH               = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter bit SKID_EN            = 1'b1
) (
    input logic           clk_in,
    input logic           rst_in,
    decode_stage_if.slave bus
);

    typedef enum logic [2:0] {
        TYPE_R    = 3'd0,
        TYPE_I    = 3'd1,
        TYPE_S    = 3'd2,
        TYPE_B    = 3'd3,
        TYPE_U    = 3'd4,
        TYPE_J    = 3'd5,
        TYPE_NONE = 3'd7
    } instr_type_e;

    typedef struct packed {
        logic [6:0]                    op;
        logic [2:0]                    f3;
        logic [6:0]                    f7;
        logic [REGFILE_ADDR_WIDTH-1:0] rs1;
        logic [REGFILE_ADDR_WIDTH-1:0] rs2;
        logic [REGFILE_ADDR_WIDTH-1:0] rd;
        logic [ARCH-1:0]               imm;
        logic [ARCH-1:0]               pc;
        instr_type_e                   ty;
        logic                          ill;
    } entry_t;

    entry_t      dec;
    entry_t      main_q;
    logic        valid_q;
    logic        ready_int;
    logic [31:0] w;
    logic [31:0] imm32;

    // Combinational decode of the word currently offered by fetch.
    always_comb begin
        w      = bus.instr_in;
        imm32  = '0;
        dec    = '0;
        dec.op = w[6:0];
        dec.pc = bus.pc_in;
        dec.ty = TYPE_NONE;
        dec.ill = 1'b1;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'b0110011: begin
                    dec.ty  = TYPE_R;
                    dec.ill = 1'b0;
                    dec.rd  = REGFILE_ADDR_WIDTH'(w[11:7]);
                    dec.rs1 = REGFILE_ADDR_WIDTH'(w[19:15]);
                    dec.rs2 = REGFILE_ADDR_WIDTH'(w[24:20]);
                    dec.f3  = w[14:12];
                    dec.f7  = w[31:25];
                end
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                    dec.ty  = TYPE_I;
                    dec.ill = 1'b0;
                    dec.rd  = REGFILE_ADDR_WIDTH'(w[11:7]);
                    dec.rs1 = REGFILE_ADDR_WIDTH'(w[19:15]);
                    dec.f3  = w[14:12];
                    imm32   = {{20{w[31]}}, w[31:20]};
                end
                7'b0100011: begin
                    dec.ty  = TYPE_S;
                    dec.ill = 1'b0;
                    dec.rs1 = REGFILE_ADDR_WIDTH'(w[19:15]);
                    dec.rs2 = REGFILE_ADDR_WIDTH'(w[24:20]);
                    dec.f3  = w[14:12];
                    imm32   = {{20{w[31]}}, w[31:25], w[11:7]};
                end
                7'b1100011: begin
                    dec.ty  = TYPE_B;
                    dec.ill = 1'b0;
                    dec.rs1 = REGFILE_ADDR_WIDTH'(w[19:15]);
                    dec.rs2 = REGFILE_ADDR_WIDTH'(w[24:20]);
                    dec.f3  = w[14:12];
                    imm32   = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec.ty  = TYPE_U;
                    dec.ill = 1'b0;
                    dec.rd  = REGFILE_ADDR_WIDTH'(w[11:7]);
                    imm32   = {w[31:12], 12'b0};
                end
                7'b1101111: begin
                    dec.ty  = TYPE_J;
                    dec.ill = 1'b0;
                    dec.rd  = REGFILE_ADDR_WIDTH'(w[11:7]);
                    imm32   = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                end
                default: begin
                    dec.ty  = TYPE_NONE;
                    dec.ill = 1'b1;
                end
            endcase
        end
        // The 32-bit immediate is sign-extended to the full datapath. On
        // ARCH=64 this makes U-type immediates extend from bit 31.
        dec.imm = ARCH'(signed'(imm32));
    end

    assign bus.op_code_out     = main_q.op;
    assign bus.func3_out       = main_q.f3;
    assign bus.func7_out       = main_q.f7;
    assign bus.rs1_out         = main_q.rs1;
    assign bus.rs2_out         = main_q.rs2;
    assign bus.rd_out          = main_q.rd;
    assign bus.imm_out         = main_q.imm;
    assign bus.pc_out          = main_q.pc;
    assign bus.instr_type_out  = main_q.ty;
    assign bus.illegal_out     = main_q.ill;
    assign bus.dec_valid_out   = valid_q;
    // Reset forces ready low. The registered ready returns the cycle rst_in drops.
    assign bus.instr_ready_out = ready_int & ~rst_in;

    generate
        if (SKID_EN) begin : g_skid
            typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

            state_e state_q;
            entry_t skid_q;
            logic   ready_q;
            logic   in_xfer;
            logic   out_xfer;

            assign ready_int = ready_q;
            assign in_xfer   = bus.instr_valid_in & ready_q;
            assign out_xfer  = valid_q & bus.dec_ready_in;

            // main_q is always the head of the FIFO. skid_q holds the second
            // entry only in S_FULL, and it moves to main_q when the head drains.
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    state_q <= S_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end else if (bus.flush_in) begin
                    state_q <= S_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end else begin
                    case (state_q)
                        S_EMPTY: begin
                            if (in_xfer) begin
                                main_q  <= dec;
                                valid_q <= 1'b1;
                                state_q <= S_ONE;
                            end
                        end
                        S_ONE: begin
                            if (in_xfer && out_xfer) begin
                                main_q <= dec;
                            end else if (in_xfer) begin
                                skid_q  <= dec;
                                ready_q <= 1'b0;
                                state_q <= S_FULL;
                            end else if (out_xfer) begin
                                valid_q <= 1'b0;
                                state_q <= S_EMPTY;
                            end
                        end
                        S_FULL: begin
                            if (out_xfer) begin
                                main_q  <= skid_q;
                                ready_q <= 1'b1;
                                state_q <= S_ONE;
                            end
                        end
                        default: begin
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= S_EMPTY;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic in_xfer;
            logic out_xfer;

            assign ready_int = ~valid_q | bus.dec_ready_in;
            assign in_xfer   = bus.instr_valid_in & ready_int;
            assign out_xfer  = valid_q & bus.dec_ready_in;

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    main_q  <= '0;
                    valid_q <= 1'b0;
                end else if (bus.flush_in) begin
                    valid_q <= 1'b0;
                end else if (in_xfer) begin
                    main_q  <= dec;
                    valid_q <= 1'b1;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Self-checking bench for decode_stage. Three instances share one stimulus
//   stream:
//     a: ARCH=32, skid buffer
//     b: ARCH=64, skid buffer
//     c: ARCH=32, single register
//   The checks come from three sources. A hand-computed decode table is
//   streamed through all three instances. Directed sequences cover
//   backpressure, flush and reset. A random phase compares every instance
//   against a FIFO/decode reference model.
module tb_decode_stage;

    typedef struct packed {
        logic        v;
        logic        r;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [2:0]  ty;
        logic        ill;
    } obs_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [2:0]  ty;
        logic        ill;
    } dec_t;

    typedef struct packed {
        logic [31:0] w;
        dec_t        d;
    } vec_t;

    typedef struct packed {
        logic [31:0] w;
        logic [63:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_v = 1'b0;
    logic [31:0] in_w = '0;
    logic [63:0] in_pc = '0;
    logic        in_fl = 1'b0;
    logic        in_dr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    item_t q2[$];
    item_t q1[$];
    vec_t  tbl[12];

    always #5 clk = ~clk;

    decode_stage_if #(.ARCH(32), .REGFILE_ADDR_WIDTH(5)) if_a();
    decode_stage_if #(.ARCH(64), .REGFILE_ADDR_WIDTH(5)) if_b();
    decode_stage_if #(.ARCH(32), .REGFILE_ADDR_WIDTH(5)) if_c();

    assign if_a.flush_in = in_fl;  assign if_a.instr_valid_in = in_v;  assign if_a.instr_in = in_w;
    assign if_a.pc_in = in_pc[31:0];  assign if_a.dec_ready_in = in_dr;
    assign if_b.flush_in = in_fl;  assign if_b.instr_valid_in = in_v;  assign if_b.instr_in = in_w;
    assign if_b.pc_in = in_pc;        assign if_b.dec_ready_in = in_dr;
    assign if_c.flush_in = in_fl;  assign if_c.instr_valid_in = in_v;  assign if_c.instr_in = in_w;
    assign if_c.pc_in = in_pc[31:0];  assign if_c.dec_ready_in = in_dr;

    decode_stage #(.ARCH(32), .REGFILE_ADDR_WIDTH(5), .SKID_EN(1'b1)) dut_a (.clk_in(clk), .rst_in(rst), .bus(if_a));
    decode_stage #(.ARCH(64), .REGFILE_ADDR_WIDTH(5), .SKID_EN(1'b1)) dut_b (.clk_in(clk), .rst_in(rst), .bus(if_b));
    decode_stage #(.ARCH(32), .REGFILE_ADDR_WIDTH(5), .SKID_EN(1'b0)) dut_c (.clk_in(clk), .rst_in(rst), .bus(if_c));

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = '{v: if_a.dec_valid_out, r: if_a.instr_ready_out, op: if_a.op_code_out,
                     f3: if_a.func3_out, f7: if_a.func7_out, rs1: if_a.rs1_out, rs2: if_a.rs2_out,
                     rd: if_a.rd_out, imm: {32'b0, if_a.imm_out}, pc: {32'b0, if_a.pc_out},
                     ty: if_a.instr_type_out, ill: if_a.illegal_out};
    assign obs_b = '{v: if_b.dec_valid_out, r: if_b.instr_ready_out, op: if_b.op_code_out,
                     f3: if_b.func3_out, f7: if_b.func7_out, rs1: if_b.rs1_out, rs2: if_b.rs2_out,
                     rd: if_b.rd_out, imm: if_b.imm_out, pc: if_b.pc_out,
                     ty: if_b.instr_type_out, ill: if_b.illegal_out};
    assign obs_c = '{v: if_c.dec_valid_out, r: if_c.instr_ready_out, op: if_c.op_code_out,
                     f3: if_c.func3_out, f7: if_c.func7_out, rs1: if_c.rs1_out, rs2: if_c.rs2_out,
                     rd: if_c.rd_out, imm: {32'b0, if_c.imm_out}, pc: {32'b0, if_c.pc_out},
                     ty: if_c.instr_type_out, ill: if_c.illegal_out};

    // Reference decode: immediates are placed at the top of a signed 64-bit
    // word and shifted arithmetically into position.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        logic signed [63:0] t;
        d = '0;
        t = '0;
        d.op  = w[6:0];
        d.ty  = 3'd7;
        d.ill = 1'b1;
        if (w[1:0] == 2'b11) begin
            if (w[6:0] == 7'h33) begin
                d.ty = 3'd0; d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                d.f3 = w[14:12]; d.f7 = w[31:25]; d.ill = 1'b0;
            end else if (w[6:0] inside {7'h13, 7'h03, 7'h67, 7'h73}) begin
                d.ty = 3'd1; d.rd = w[11:7]; d.rs1 = w[19:15]; d.f3 = w[14:12]; d.ill = 1'b0;
                t = {w[31:20], 52'b0};
                d.imm = t >>> 52;
            end else if (w[6:0] == 7'h23) begin
                d.ty = 3'd2; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f3 = w[14:12]; d.ill = 1'b0;
                t = {w[31:25], w[11:7], 52'b0};
                d.imm = t >>> 52;
            end else if (w[6:0] == 7'h63) begin
                d.ty = 3'd3; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f3 = w[14:12]; d.ill = 1'b0;
                t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 51'b0};
                d.imm = t >>> 51;
            end else if (w[6:0] inside {7'h37, 7'h17}) begin
                d.ty = 3'd4; d.rd = w[11:7]; d.ill = 1'b0;
                t = {w[31:12], 44'b0};
                d.imm = t >>> 32;
            end else if (w[6:0] == 7'h6F) begin
                d.ty = 3'd5; d.rd = w[11:7]; d.ill = 1'b0;
                t = {w[31], w[19:12], w[20], w[30:21], 1'b0, 43'b0};
                d.imm = t >>> 43;
            end
        end
        return d;
    endfunction

    function automatic obs_t from_dec(input bit v, input bit r, input dec_t d,
                                      input logic [63:0] pc, input bit narrow);
        obs_t o;
        o = '0;
        o.v = v; o.r = r; o.op = d.op; o.f3 = d.f3; o.f7 = d.f7;
        o.rs1 = d.rs1; o.rs2 = d.rs2; o.rd = d.rd; o.ty = d.ty; o.ill = d.ill;
        o.imm = narrow ? {32'b0, d.imm[31:0]} : d.imm;
        o.pc  = narrow ? {32'b0, pc[31:0]} : pc;
        return o;
    endfunction

    function automatic vec_t mkv(input logic [31:0] w, input logic [2:0] ty, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [63:0] imm, input logic ill);
        vec_t x;
        x.w = w;
        x.d = '{op: op, f3: f3, f7: f7, rs1: rs1, rs2: rs2, rd: rd, imm: imm, ty: ty, ill: ill};
        return x;
    endfunction

    // The handshake flags are always compared. The decoded fields are compared
    // only when a valid entry is expected.
    task automatic check(input string nm, input obs_t got, input obs_t exp, input bit fields);
        obs_t g, e;
        g = got;
        e = exp;
        if (!fields) begin
            g = '0; g.v = got.v; g.r = got.r;
            e = '0; e.v = exp.v; e.r = exp.r;
        end
        n_checks++;
        if (g === e) n_pass++;
        else $display("FAIL %s t=%0t: got %h required %h", nm, $time, g, e);
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t: got %b required %b", nm, $time, got, exp);
    endtask

    // One cycle against the FIFO model: the skid instances behave as a
    // capacity-2 FIFO whose ready means "fewer than 2 held". The single
    // register behaves as a capacity-1 FIFO that is ready when empty or draining.
    task automatic step(input bit v, input logic [31:0] w, input logic [63:0] pc,
                        input bit fl, input bit dr);
        bit    r2, r1;
        item_t h2, h1;
        in_v = v; in_w = w; in_pc = pc; in_fl = fl; in_dr = dr;
        #1;
        r2 = q2.size() < 2;
        r1 = (q1.size() == 0) || dr;
        h2 = (q2.size() > 0) ? q2[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        check("model_a", obs_a, from_dec(q2.size() > 0, r2, ref_decode(h2.w), h2.pc, 1'b1), q2.size() > 0);
        check("model_b", obs_b, from_dec(q2.size() > 0, r2, ref_decode(h2.w), h2.pc, 1'b0), q2.size() > 0);
        check("model_c", obs_c, from_dec(q1.size() > 0, r1, ref_decode(h1.w), h1.pc, 1'b1), q1.size() > 0);
        @(posedge clk);
        if (q2.size() > 0 && dr) void'(q2.pop_front());
        if (fl) q2.delete(); else if (v && r2) q2.push_back('{w: w, pc: pc});
        if (q1.size() > 0 && dr) void'(q1.pop_front());
        if (fl) q1.delete(); else if (v && r1) q1.push_back('{w: w, pc: pc});
        @(negedge clk);
    endtask

    task automatic do_reset();
        obs_t z;
        rst = 1'b1; in_v = 1'b1; in_w = 32'h00500093; in_fl = 1'b0; in_dr = 1'b0;
        #1;
        chk1("rst_rdy_a", if_a.instr_ready_out, 1'b0);
        chk1("rst_rdy_b", if_b.instr_ready_out, 1'b0);
        chk1("rst_rdy_c", if_c.instr_ready_out, 1'b0);
        @(posedge clk);
        @(negedge clk);
        z = '0;
        check("rst_a", obs_a, z, 1'b1);
        check("rst_b", obs_b, z, 1'b1);
        check("rst_c", obs_c, z, 1'b1);
        rst = 1'b0; in_v = 1'b0;
        #1;
        z.r = 1'b1;
        check("post_rst_a", obs_a, z, 1'b1);
        check("post_rst_b", obs_b, z, 1'b1);
        check("post_rst_c", obs_c, z, 1'b1);
        q2.delete();
        q1.delete();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pc;
        logic [31:0] w;
        tbl[0]  = mkv(32'h00500093, 3'd1, 7'h13, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  64'd5, 1'b0);
        tbl[1]  = mkv(32'hFE000FE3, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        tbl[2]  = mkv(32'h800000B7, 3'd4, 7'h37, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  64'hFFFF_FFFF_8000_0000, 1'b0);
        tbl[3]  = mkv(32'h00000000, 3'd7, 7'h00, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'd0, 1'b1);
        tbl[4]  = mkv(32'h0000007F, 3'd7, 7'h7F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'd0, 1'b1);
        tbl[5]  = mkv(32'h40B50533, 3'd0, 7'h33, 3'd0, 7'h20, 5'd10, 5'd11, 5'd10, 64'd0, 1'b0);
        tbl[6]  = mkv(32'hFE512E23, 3'd2, 7'h23, 3'd2, 7'h00, 5'd2,  5'd5,  5'd0,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        tbl[7]  = mkv(32'h001000EF, 3'd5, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  64'h800, 1'b0);
        tbl[8]  = mkv(32'h00001017, 3'd4, 7'h17, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'h1000, 1'b0);
        tbl[9]  = mkv(32'hFFF00073, 3'd1, 7'h73, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        tbl[10] = mkv(32'h00500091, 3'd7, 7'h11, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'd0, 1'b1);
        tbl[11] = mkv(32'h00822183, 3'd1, 7'h03, 3'd2, 7'h00, 5'd4,  5'd0,  5'd3,  64'd8, 1'b0);

        do_reset();

        // Table stream with execute always ready: one result per cycle.
        for (int k = 0; k <= 12; k++) begin
            in_v = (k < 12); in_fl = 1'b0; in_dr = 1'b1;
            if (k < 12) begin
                in_w  = tbl[k].w;
                in_pc = 64'hABCD_0000_0000_1000 + 64'(k * 4);
            end
            #1;
            if (k > 0) begin
                pc = 64'hABCD_0000_0000_1000 + 64'((k - 1) * 4);
                check("tbl_a", obs_a, from_dec(1'b1, 1'b1, tbl[k-1].d, pc, 1'b1), 1'b1);
                check("tbl_b", obs_b, from_dec(1'b1, 1'b1, tbl[k-1].d, pc, 1'b0), 1'b1);
                check("tbl_c", obs_c, from_dec(1'b1, 1'b1, tbl[k-1].d, pc, 1'b1), 1'b1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_v = 1'b0;
        @(negedge clk);

        // Backpressure: two accepts fill the skid instances, then hold and release.
        do_reset();
        step(1'b1, tbl[0].w, 64'h100, 1'b0, 1'b0);
        step(1'b1, tbl[5].w, 64'h104, 1'b0, 1'b0);
        chk1("full_rdy_a", if_a.instr_ready_out, 1'b0);
        chk1("full_hold_b", (obs_b.pc == 64'h100) && obs_b.v, 1'b1);
        step(1'b1, tbl[6].w, 64'h108, 1'b0, 1'b0);
        step(1'b1, tbl[6].w, 64'h108, 1'b0, 1'b0);
        step(1'b1, tbl[6].w, 64'h108, 1'b0, 1'b1);
        step(1'b1, tbl[6].w, 64'h108, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);

        // Flush while full, with a new instruction offered in the same cycle.
        step(1'b1, tbl[1].w, 64'h200, 1'b0, 1'b0);
        step(1'b1, tbl[2].w, 64'h204, 1'b0, 1'b0);
        step(1'b1, tbl[7].w, 64'h208, 1'b1, 1'b0);
        chk1("flush_valid_a", if_a.dec_valid_out, 1'b0);
        chk1("flush_ready_a", if_a.instr_ready_out, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        // Flush coinciding with an output transfer.
        step(1'b1, tbl[8].w, 64'h300, 1'b0, 1'b0);
        step(1'b1, tbl[9].w, 64'h304, 1'b1, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);

        // Reset in the middle of a stream, with the skid instances full.
        step(1'b1, tbl[3].w, 64'h400, 1'b0, 1'b0);
        step(1'b1, tbl[4].w, 64'h404, 1'b0, 1'b0);
        do_reset();

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 1)
                w = (tbl[$urandom_range(0, 11)].w & 32'h0000_007F) | ($urandom & 32'hFFFF_FF80);
            else
                w = $urandom;
            pc = {$urandom, $urandom};
            step($urandom_range(0, 3) != 0, w, pc, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
